control_pc: RTL and testbench
=============================

# control_pc

Program-counter sequencer for the fetch stage. It holds the current PC, issues fetch requests to instruction memory over a req/ack handshake, and advances by 4 after each accepted fetch. Taken branches redirect it to `branch_pc + (branch_offset << 2)`, the same target arithmetic the branch adder produces. Wrong-path fetches still in flight when a branch resolves are squashed, and fetching pauses while the pipeline stalls.

## Interface
Parameters:
- `RESET_ADDR`, default `32'h00000000`: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `branch_taken`  in  1  one-cycle pulse from execute: the branch is taken.
- `branch_pc`  in  32  PC of the branching instruction; sampled when `branch_taken`=1.
- `branch_offset`  in  32  word offset; sampled when `branch_taken`=1.
- `stall`  in  1  pipeline cannot accept a new instruction.
- `fetch_ack`  in  1  instruction memory accepts the current request this cycle.
- `fetch_req`  out  1  fetch request valid.
- `fetch_addr`  out  32  fetch address; stable while `fetch_req`=1 and `fetch_ack`=0.
- `instr_valid`  out  1  one-cycle pulse: the fetch completed last cycle is on the correct path.
- `instr_pc`  out  32  address of the instruction flagged by `instr_valid`.

## Operation
- State: `pc` (32), `pend` (1), `pend_tgt` (32), FSM {IDLE, FETCH, STALL}.
- Target arithmetic is `tgt = branch_pc + (branch_offset << 2)`, modulo 2^32.
  - Bits shifted out of the top are dropped.
  - Wrap-around is silent, e.g. `FFFFFFFC + (1<<2) = 00000000`.
- Sequential increment is `pc + 4`, also modulo 2^32.
- IDLE: `fetch_req`=0. Moves to FETCH on the next cycle unconditionally.
  - `branch_taken` in IDLE loads `pc<=tgt` directly.
- FETCH: `fetch_req`=1 and `fetch_addr`=`pc`. A request is never withdrawn before `fetch_ack`.
- FETCH, `fetch_ack`=1, `pend`=0, `branch_taken`=0:
  - next cycle `instr_valid`=1 and `instr_pc`=old `pc`.
  - `pc<=pc+4`.
  - If `stall`=1 go to STALL, else stay in FETCH (back-to-back requests allowed).
- FETCH, `branch_taken`=1, `fetch_ack`=0: `pend<=1` and `pend_tgt<=tgt`. The request stays unchanged. A later `branch_taken` before the ack overwrites `pend_tgt`.
- FETCH, `fetch_ack`=1 with `pend`=1 or `branch_taken`=1:
  - the returned fetch is squashed (`instr_valid` stays 0).
  - `pc<=tgt` if `branch_taken`=1 (newest wins), else `pc<=pend_tgt`.
  - `pend<=0`.
  - Next state follows `stall` as in the plain ack case.
- `stall`=1 in FETCH without `fetch_ack` has no effect until the ack arrives.
- STALL: `fetch_req`=0. `branch_taken` loads `pc<=tgt` directly. Returns to FETCH on the first cycle with `stall`=0.

## Timing
- Reset values: `pc`=`RESET_ADDR`, `pend`=0, state=IDLE, `fetch_req`=0, `fetch_addr`=`RESET_ADDR`, `instr_valid`=0, `instr_pc`=0.
- Reset has priority over every input. Asserted mid-request, it abandons the request: `fetch_req`=0 on the cycle after the reset edge, and pending branches are discarded.
- First request:
  - cycle 0 is the first edge with `reset`=0 (IDLE).
  - `fetch_req`=1 with `fetch_addr`=`RESET_ADDR` from cycle 1.
- Ack at cycle k:
  - `instr_valid` and `instr_pc` are registered and visible at k+1.
  - `fetch_addr` shows the new `pc` at k+1, with `fetch_req`=1 unless stalling.
- `fetch_ack` is only meaningful while `fetch_req`=1 and is ignored otherwise.
- Branch redirect latency:
  - No outstanding request (IDLE/STALL): the target appears on `fetch_addr` at the first subsequent request.
  - Request outstanding: the target appears on the cycle after the ack.
- Sustained throughput is one fetch per cycle when `fetch_ack` is held at 1.

## Test plan
- Reset release, then `fetch_ack`=1 constant -> `fetch_addr` = 0, 4, 8, C on consecutive cycles; `instr_valid` pulses with `instr_pc` = 0, 4, 8 one cycle later.
- Branch at ack: while `fetch_addr`=8, pulse `branch_taken` with `branch_pc`=4, `branch_offset`=3, `fetch_ack`=1 -> fetch at 8 squashed (no `instr_valid`), next `fetch_addr`=`10`.
- Pending branch: `fetch_ack`=0 at `fetch_addr`=`20`.
  - pulse `branch_pc`=`20`, offset=`-2` (`FFFFFFFE`), then another with `branch_pc`=`20`, offset=1, then ack two cycles later.
  - `fetch_addr` held at `20` until the ack; the ack is squashed; next `fetch_addr`=`24` (newest branch wins).
- Stall: `stall`=1 together with an ack at `fetch_addr`=`C` -> `instr_valid` for `C`, `fetch_req`=0 while stalled; release `stall` -> `fetch_req`=1 with `fetch_addr`=`10` the next cycle.
- Wrap: `branch_pc`=`FFFFFFF8`, offset=2 while in STALL -> next request `fetch_addr`=`00000000`; a sequential fetch from `FFFFFFFC` -> `00000000`.
- Reset mid-request with `pend`=1 -> `fetch_req`=0 next cycle; after release, first `fetch_addr`=`RESET_ADDR` and no stale redirect.

Source files
------------

// File: rtl/control_pc.sv
// Fetch-stage program-counter sequencer: issues req/ack fetches, advances by 4,
// and redirects on taken branches, squashing wrong-path fetches still in flight.
module control_pc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset,
  input  logic        stall,
  input  logic        fetch_ack,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  output logic        instr_valid,
  output logic [31:0] instr_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        fetch_req_q, fetch_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] tgt;

  // Shifted-out offset bits are dropped and the sum wraps modulo 2^32.
  assign tgt = branch_pc + {branch_offset[29:0], 2'b00};

  // Next-state, PC and pending-redirect logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    instr_valid_d = 1'b0;
    instr_pc_d    = instr_pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_taken) begin
          pc_d = tgt;
        end else begin
          pc_d = pc_q;
        end
      end
      FETCH: begin
        if (fetch_ack) begin
          if (pend_q || branch_taken) begin
            // Returned fetch is wrong-path; the newest branch wins.
            pc_d = branch_taken ? tgt : pend_tgt_q;
          end else begin
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 32'd4;
          end
          pend_d  = 1'b0;
          state_d = stall ? STALL : FETCH;
        end else if (branch_taken) begin
          pend_d     = 1'b1;
          pend_tgt_d = tgt;
        end else begin
          state_d = FETCH;
        end
      end
      STALL: begin
        if (branch_taken) begin
          pc_d = tgt;
        end else begin
          pc_d = pc_q;
        end
        if (!stall) begin
          state_d = FETCH;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    fetch_req_d = (state_d == FETCH);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_ADDR;
      pend_q        <= 1'b0;
      pend_tgt_q    <= 32'h0000_0000;
      fetch_req_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_tgt_q    <= pend_tgt_d;
      fetch_req_q   <= fetch_req_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign fetch_req   = fetch_req_q;
  assign fetch_addr  = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_control_pc.sv
// Directed, table-driven bench for control_pc: one vector per clock cycle,
// plus a hand-written back-to-back throughput sequence.
module tb_control_pc;

  localparam logic [31:0] RA = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic        stall;
  logic        fetch_ack;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        instr_valid;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        bt;
    logic [31:0] bpc;
    logic [31:0] boff;
    logic        stl;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        chk_ipc;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  control_pc #(.RESET_ADDR(RA)) dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_offset(branch_offset), .stall(stall), .fetch_ack(fetch_ack),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .instr_valid(instr_valid),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic bt, input logic [31:0] bpc,
                     input logic [31:0] boff, input logic stl, input logic ack,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic chk_ipc, input logic [31:0] e_ipc);
    vec_t v;
    v.rst = rst; v.bt = bt; v.bpc = bpc; v.boff = boff; v.stl = stl; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.chk_ipc = chk_ipc; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic bt, input logic [31:0] bpc,
                       input logic [31:0] boff, input logic stl, input logic ack);
    reset = rst; branch_taken = bt; branch_pc = bpc; branch_offset = boff;
    stall = stl; fetch_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic e_req, input logic [31:0] e_addr,
                         input logic e_iv, input logic chk_ipc, input logic [31:0] e_ipc);
    checks++;
    if (fetch_req !== e_req || fetch_addr !== e_addr || instr_valid !== e_iv ||
        (chk_ipc && instr_pc !== e_ipc)) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h iv=%b ipc=%h, want req=%b addr=%h iv=%b ipc=%h%s",
               name, fetch_req, fetch_addr, instr_valid, instr_pc,
               e_req, e_addr, e_iv, e_ipc, chk_ipc ? "" : "(unchecked)");
    end
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_pc = 32'h0; branch_offset = 32'h0;
    stall = 1'b0; fetch_ack = 1'b0;

    //   rst   bt    bpc           boff          stl   ack   req   addr          iv    chk   ipc
    add(1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, RA,           1'b0, 1'b1, 32'h0);
    add(1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, RA,           1'b0, 1'b1, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, RA,           1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, RA + 32'd4,   1'b1, 1'b1, RA);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, RA + 32'd8,   1'b1, 1'b1, RA + 32'd4);
    // branch coincident with the ack: fetch at RA+8 squashed, redirect to 4+(3<<2)
    add(1'b0, 1'b1, 32'h4,        32'h3,        1'b0, 1'b1, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h14,       1'b1, 1'b1, 32'h10);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h18,       1'b1, 1'b1, 32'h14);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h1C,       1'b1, 1'b1, 32'h18);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h20,       1'b1, 1'b1, 32'h1C);
    // two pending branches before the ack; the second (0x24) must win
    add(1'b0, 1'b1, 32'h20,       32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b1, 32'h20,       32'h1,        1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h24,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h28,       1'b1, 1'b1, 32'h24);
    // stall with an ack, ack ignored while stalled, wrapping branch in STALL
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 32'h2C,       1'b1, 1'b1, 32'h28);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 32'h2C,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b1, 32'hFFFFFFF8, 32'h2,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
    // redirect to FFFFFFFC, then sequential wrap to 0
    add(1'b0, 1'b1, 32'hFFFFFFF0, 32'h3,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC);
    // stall without ack has no effect; then a pending branch abandoned by reset
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b1, 32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, RA,           1'b0, 1'b1, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, RA,           1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, RA + 32'd4,   1'b1, 1'b1, RA);
    // branch taken in IDLE loads the PC directly
    add(1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, RA,           1'b0, 1'b1, 32'h0);
    add(1'b0, 1'b1, 32'h40,       32'h1,        1'b0, 1'b0, 1'b1, 32'h44,       1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h48,       1'b1, 1'b1, 32'h44);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].bt, vecs[i].bpc, vecs[i].boff, vecs[i].stl, vecs[i].ack);
      compare($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
              vecs[i].chk_ipc, vecs[i].e_ipc);
    end

    // Sustained one-fetch-per-cycle throughput from 0x48.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      compare($sformatf("burst%0d", i), 1'b1, 32'h4C + 32'(4 * i), 1'b1, 1'b1,
              32'h48 + 32'(4 * i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
